// File: rtl/sd_block_arbiter.sv
// Four-way round-robin arbiter sharing one SD block host among floppy/hdd requesters.
// Optional ISSUE-state watchdog is built when SD_ARB_TIMEOUT_EN is defined.
module sd_block_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic [3:0]   req_rd,
    input  logic [3:0]   req_wr,
    input  logic [127:0] req_lba,
    input  logic [31:0]  req_buff_din,
    output logic [3:0]   req_ack,
    output logic [3:0]   req_done,
    output logic [3:0]   req_err,
    output logic         sd_rd,
    output logic         sd_wr,
    output logic [31:0]  sd_lba,
    input  logic         sd_ack,
    output logic [7:0]   sd_buff_din,
    output logic [3:0]   grant,
    output logic         hdd_wait
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [3:0]  grant_nxt;
    logic [3:0]  req_done_nxt;
    logic [31:0] sd_lba_nxt;
    logic        sd_rd_nxt, sd_wr_nxt;
    logic [1:0]  owner, owner_nxt;
    logic [1:0]  last_owner, last_owner_nxt;
    logic        ack_q;
    logic        ack_rise, ack_fall;
    logic [3:0]  req_any;
    logic        sel_found;
    logic [1:0]  sel_idx;
    logic [1:0]  cand;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;
    logic [3:0]       req_err_nxt;
`else
    assign req_err = 4'(0 * TIMEOUT_CYCLES);
`endif

    assign ack_rise = sd_ack & ~ack_q;
    assign ack_fall = ~sd_ack & ack_q;
    assign req_any  = req_rd | req_wr;
    assign hdd_wait = grant[1] | grant[3] | req_any[1] | req_any[3];
    assign req_ack  = grant & {4{sd_ack}};

    // Write-data mux follows the current grant; zero with no owner.
    always_comb begin
        sd_buff_din = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) sd_buff_din = sd_buff_din | req_buff_din[8*i +: 8];
        end
    end

    // Round-robin search starting just after the last owner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = 2'(last_owner + 2'(i));
            if (!sel_found && req_any[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        req_done_nxt   = 4'b0000;
        sd_lba_nxt     = sd_lba;
        sd_rd_nxt      = sd_rd;
        sd_wr_nxt      = sd_wr;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
`ifdef SD_ARB_TIMEOUT_EN
        req_err_nxt    = 4'b0000;
        wd_cnt_nxt     = '0;
`endif
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt  = ISSUE;
                    owner_nxt  = sel_idx;
                    grant_nxt  = 4'(4'b0001 << sel_idx);
                    sd_lba_nxt = req_lba[32*sel_idx +: 32];
                    // Read wins when both are pending; the write waits for a later grant.
                    sd_rd_nxt  = req_rd[sel_idx];
                    sd_wr_nxt  = ~req_rd[sel_idx];
                end
            end
            ISSUE: begin
                if (ack_rise) begin
                    state_nxt = XFER;
                    sd_rd_nxt = 1'b0;
                    sd_wr_nxt = 1'b0;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt      = IDLE;
                    sd_rd_nxt      = 1'b0;
                    sd_wr_nxt      = 1'b0;
                    grant_nxt      = 4'b0000;
                    req_err_nxt    = grant;
                    last_owner_nxt = owner;
                end else begin
                    wd_cnt_nxt = CNT_W'(wd_cnt + 1'b1);
                end
`endif
            end
            XFER: begin
                if (ack_fall) begin
                    state_nxt    = DONE;
                    req_done_nxt = grant;
                    grant_nxt    = 4'b0000;
                end
            end
            default: begin
                state_nxt      = IDLE;
                grant_nxt      = 4'b0000;
                last_owner_nxt = owner;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 4'b0000;
            req_done   <= 4'b0000;
            sd_lba     <= 32'h0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            owner      <= 2'd0;
            last_owner <= 2'd3;
            ack_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            req_done   <= req_done_nxt;
            sd_lba     <= sd_lba_nxt;
            sd_rd      <= sd_rd_nxt;
            sd_wr      <= sd_wr_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            ack_q      <= sd_ack;
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            req_err <= 4'b0000;
        end else begin
            wd_cnt  <= wd_cnt_nxt;
            req_err <= req_err_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed bench for sd_block_arbiter: grant order, latching, read priority, reset and watchdog.
module tb_sd_block_arbiter;

    logic         clk_sys = 1'b0;
    logic         reset;
    logic [3:0]   req_rd, req_wr;
    logic [127:0] req_lba;
    logic [31:0]  req_buff_din;
    logic [3:0]   req_ack, req_done, req_err, grant;
    logic         sd_rd, sd_wr, sd_ack, hdd_wait;
    logic [31:0]  sd_lba;
    logic [7:0]   sd_buff_din;

    int checks   = 0;
    int failures = 0;

    sd_block_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_buff_din(req_buff_din),
        .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_ack(sd_ack),
        .sd_buff_din(sd_buff_din), .grant(grant), .hdd_wait(hdd_wait)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Entered right after the edge into ISSUE; runs one ack handshake to IDLE.
    task automatic serve(input logic [3:0] g, input logic rd, input logic wr,
                         input logic [31:0] lba, input int ack_len);
        chk("issue_grant", 32'(grant), 32'(g));
        chk("issue_rd", 32'(sd_rd), 32'(rd));
        chk("issue_wr", 32'(sd_wr), 32'(wr));
        chk("issue_lba", sd_lba, lba);
        sd_ack = 1'b1;
        tick();
        chk("xfer_strobe", 32'({sd_rd, sd_wr}), 32'(0));
        chk("xfer_ack_route", 32'(req_ack), 32'(g));
        for (int i = 1; i < ack_len; i++) tick();
        chk("xfer_grant_stable", 32'(grant), 32'(g));
        chk("xfer_lba_stable", sd_lba, lba);
        sd_ack = 1'b0;
        tick();
        chk("done_pulse", 32'(req_done), 32'(g));
        chk("done_grant", 32'(grant), 32'(0));
        chk("done_err", 32'(req_err), 32'(0));
        tick();
        chk("idle_done", 32'(req_done), 32'(0));
        chk("idle_grant", 32'(grant), 32'(0));
    endtask

    initial begin
        reset = 1'b1; req_rd = 4'b0; req_wr = 4'b0; sd_ack = 1'b0;
        req_lba      = {32'h3000_0003, 32'hABCD_0002, 32'h0000_0123, 32'h1000_0000};
        req_buff_din = 32'h44_33_5A_11;
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_strobe", 32'({sd_rd, sd_wr}), 32'(0));
        chk("rst_lba", sd_lba, 32'h0);
        chk("rst_pulses", 32'({req_done, req_err}), 32'(0));
        chk("rst_muxes", 32'({req_ack, sd_buff_din, hdd_wait}), 32'(0));
        reset = 1'b0;
        tick();

        // ack while idle is ignored
        sd_ack = 1'b1;
        tick();
        chk("idle_ack_route", 32'(req_ack), 32'(0));
        chk("idle_ack_grant", 32'(grant), 32'(0));
        sd_ack = 1'b0;
        tick();
        chk("idle_ack_state", 32'({sd_rd, sd_wr, req_done}), 32'(0));

        // hdd0 read, 512-cycle transfer, request dropped while granted
        req_rd = 4'b0010;
        tick();
        chk("hdd0_wait", 32'(hdd_wait), 32'(1));
        chk("hdd0_buff", 32'(sd_buff_din), 32'h5A);
        req_rd = 4'b0000;
        req_lba[63:32] = 32'hDEAD_BEEF;
        serve(4'b0010, 1'b1, 1'b0, 32'h0000_0123, 512);
        req_lba[63:32] = 32'h0000_0123;
        chk("hdd0_wait_clear", 32'(hdd_wait), 32'(0));

        // all four requesting after reset: 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_rd = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] g;
            g = 4'(4'b0001 << (k % 4));
            tick();
            serve(g, 1'b1, 1'b0, req_lba[32*(k%4) +: 32], 3);
        end

        // read/write both on index 2: read first, write on next grant
        req_rd = 4'b0100; req_wr = 4'b0100;
        tick();
        req_rd = 4'b0000;
        serve(4'b0100, 1'b1, 1'b0, 32'hABCD_0002, 2);
        tick();
        serve(4'b0100, 1'b0, 1'b1, 32'hABCD_0002, 2);
        req_wr = 4'b0000;

        // reset mid-transfer
        req_rd = 4'b0001;
        tick();
        chk("mid_grant", 32'(grant), 32'(1));
        sd_ack = 1'b1;
        tick();
        chk("mid_xfer_ack", 32'(req_ack), 32'(1));
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'(0));
        chk("mid_rst_out", 32'({sd_rd, sd_wr, req_done, req_err, req_ack, sd_buff_din}), 32'(0));
        chk("mid_rst_lba", sd_lba, 32'h0);
        sd_ack = 1'b0; req_rd = 4'b0000;
        tick();
        chk("mid_rst_done", 32'(req_done), 32'(0));
        reset = 1'b0;
        req_wr = 4'b1000;
        tick();
        chk("hdd1_wait", 32'(hdd_wait), 32'(1));
        req_wr = 4'b0000;
        serve(4'b1000, 1'b0, 1'b1, 32'h3000_0003, 2);

`ifdef SD_ARB_TIMEOUT_EN
        req_wr = 4'b0001;
        tick();
        req_wr = 4'b0000;
        chk("to_enter", 32'({grant, sd_wr}), 32'({4'b0001, 1'b1}));
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_wait_wr", 32'({sd_wr, req_err}), 32'({1'b1, 4'b0000}));
        end
        tick();
        chk("to_strobe", 32'(sd_wr), 32'(0));
        chk("to_err", 32'(req_err), 32'(1));
        chk("to_no_done", 32'(req_done), 32'(0));
        chk("to_grant", 32'(grant), 32'(0));
        tick();
        chk("to_err_clear", 32'({req_err, req_done}), 32'(0));
`else
        req_wr = 4'b0001;
        tick();
        req_wr = 4'b0000;
        for (int i = 0; i < 40; i++) tick();
        chk("no_to_wait", 32'({grant, sd_wr}), 32'({4'b0001, 1'b1}));
        chk("no_to_err", 32'(req_err), 32'(0));
        serve(4'b0001, 1'b0, 1'b1, 32'h1000_0000, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
